// File: rtl/fifo_rd_drainer.sv
// rtl/fifo_rd_drainer.sv - read-domain FIFO drainer feeding a valid/ready stream via a skid buffer
// Define FIFO_RD_DRAIN_CNT_EN to add the saturating rd_count transfer counter output.
module fifo_rd_drainer #(
  parameter int FIFO_WIDTH = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  drain_en,
  input  logic                  flush,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
`ifdef FIFO_RD_DRAIN_CNT_EN
  output logic [31:0]           rd_count,
`endif
  output logic                  busy
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam logic [OW:0]   DEPTH_W = (OW+1)'(SKID_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [OW:0]           fill;
  logic                  capture;
  logic                  xfer;

  always_comb begin
    // Reserve a slot for the word already in flight so a pop can never overrun the buffer.
    fill       = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
    r_en       = (state_q == RUN) && !empty && !flush && (fill < DEPTH_W);
    m_valid    = (occ_q != '0);
    m_data     = mem_q[head_q];
    busy       = m_valid || inflight_q;
    capture    = inflight_q && !flush;
    xfer       = m_valid && m_ready;

    state_d    = state_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = r_en;
    mem_d      = mem_q;

    case (state_q)
      IDLE:    if (drain_en) state_d = RUN;
      RUN:     if (!drain_en) state_d = DRAIN;
      DRAIN:   if (occ_q == '0 && !inflight_q) state_d = drain_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      mem_d[tail_q] = data_out;
      tail_d        = tail_q + PTR_ONE;
    end
    if (xfer) head_d = head_q + PTR_ONE;

    if (capture && !xfer)      occ_d = occ_q + OCC_ONE;
    else if (!capture && xfer) occ_d = occ_q - OCC_ONE;

    if (flush) begin
      state_d    = IDLE;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
    end
  end

`ifdef FIFO_RD_DRAIN_CNT_EN
  logic [31:0] rd_count_q, rd_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    if (flush)                          rd_count_d = '0;
    else if (xfer && rd_count_q != '1)  rd_count_d = rd_count_q + 32'd1;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) rd_count_q <= '0;
    else      rd_count_q <= rd_count_d;
  end

  assign rd_count = rd_count_q;
`endif

endmodule
